// File: rtl/otter_csr_intr_pkg.sv
// otter_csr_intr_pkg: CSR addresses, bit positions and SYSTEM-instruction constants
package otter_csr_intr_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam logic [6:0]  OPCODE_SYS     = 7'b1110011;
  localparam logic [2:0]  FUNC_SYS_CSRRW = 3'b001;
  localparam logic [31:0] INSTRN_MRET    = 32'h3020_0073;
endpackage

// File: rtl/otter_csr_intr_sync_edge.sv
// otter_sync_edge: multi-flop synchronizer for an async level, plus a one-cycle rising-edge pulse
module otter_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
endmodule

// File: rtl/otter_csr_intr.sv
// otter_csr_intr: machine-mode CSR file and external-interrupt controller for the OTTER MCU
module otter_csr_intr
  import otter_csr_intr_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MCAUSE_EXT  = 32'h8000_000B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intrpt_req,
  input  logic        exec_en,
  input  logic [31:0] instrn,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  output logic        intrpt_taken,
  output logic [31:0] csr_r_data,
  output logic [31:0] mtvec,
  output logic [31:0] mepc,
  output logic        mstatus_mie
);
  logic        rise;
  logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, pend_q, pend_d;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, rd_val;
  logic [11:0] addr;
  logic        is_csrrw, is_mret, do_csrrw, do_mret;

  otter_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (intrpt_req),
    .rise_o  (rise)
  );

  assign addr         = instrn[31:20];
  assign is_csrrw     = instrn[6:0] == OPCODE_SYS && instrn[14:12] == FUNC_SYS_CSRRW;
  assign is_mret      = instrn == INSTRN_MRET;
  // Registered state only, so no combinational path from the instruction word
  assign intrpt_taken = exec_en & pend_q & mie_q & meie_q;
  assign do_csrrw     = exec_en & ~intrpt_taken & is_csrrw;
  assign do_mret      = exec_en & ~intrpt_taken & is_mret;

  always_comb begin
    rd_val = '0;
    case (addr)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE_BIT]  = mie_q;
        rd_val[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:    rd_val[MIE_MEIE_BIT] = meie_q;
      CSR_MTVEC:  rd_val = mtvec_q;
      CSR_MEPC:   rd_val = mepc_q;
      CSR_MCAUSE: rd_val = mcause_q;
      CSR_MIP:    rd_val[MIE_MEIE_BIT] = pend_q;
      default:    rd_val = '0;
    endcase
  end

  assign csr_r_data = do_csrrw ? rd_val : '0;

  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    // A new edge in the taken cycle re-arms the pending flag
    pend_d   = rise | (pend_q & ~intrpt_taken);
    if (intrpt_taken) begin
      mepc_d   = pc & ~32'h3;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mcause_d = MCAUSE_EXT;
    end else if (do_csrrw) begin
      case (addr)
        CSR_MSTATUS: begin
          mie_d  = rs1_data[MSTATUS_MIE_BIT];
          mpie_d = rs1_data[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:    meie_d   = rs1_data[MIE_MEIE_BIT];
        CSR_MTVEC:  mtvec_d  = rs1_data & ~32'h3;
        CSR_MEPC:   mepc_d   = rs1_data & ~32'h3;
        CSR_MCAUSE: mcause_d = rs1_data;
        default:    ;
      endcase
    end else if (do_mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      meie_q   <= 1'b0;
      pend_q   <= 1'b0;
      mtvec_q  <= MTVEC_RST;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      meie_q   <= meie_d;
      pend_q   <= pend_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  assign mtvec       = mtvec_q;
  assign mepc        = mepc_q;
  assign mstatus_mie = mie_q;
endmodule

// File: tb/tb_otter_csr_intr.sv
// tb_otter_csr_intr: scoreboard bench for the OTTER CSR file and interrupt controller
module tb_otter_csr_intr;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] MRET      = 32'h3020_0073;

  typedef struct {
    logic        taken;
    logic [31:0] rd;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        intrpt_req = 1'b0;
  logic        exec_en = 1'b0;
  logic [31:0] instrn = NOP;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic        intrpt_taken;
  logic [31:0] csr_r_data, mtvec, mepc;
  logic        mstatus_mie;
  int          errors = 0;
  int          checks = 0;
  exp_t        sb[$];

  otter_csr_intr #(.SYNC_STAGES(2), .MTVEC_RST(MTVEC_RST), .MCAUSE_EXT(32'h8000_000B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .intrpt_req   (intrpt_req),
    .exec_en      (exec_en),
    .instrn       (instrn),
    .pc           (pc),
    .rs1_data     (rs1_data),
    .intrpt_taken (intrpt_taken),
    .csr_r_data   (csr_r_data),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .mstatus_mie  (mstatus_mie)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] csrrw(input logic [11:0] a);
    return {a, 5'd1, 3'b001, 5'd2, 7'b1110011};
  endfunction

  task automatic idle(input int n);
    exec_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic e, input logic [31:0] ins, input logic [31:0] p,
                      input logic [31:0] r, input logic et, input logic [31:0] erd, input string nm);
    exp_t x;
    exec_en = e; instrn = ins; pc = p; rs1_data = r;
    sb.push_back('{et, erd, nm});
    @(negedge clk);
    x = sb.pop_front();
    checks++;
    if (intrpt_taken !== x.taken) begin
      errors++;
      $display("FAIL %s taken: got %b expected %b", x.name, intrpt_taken, x.taken);
    end
    checks++;
    if (csr_r_data !== x.rd) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", x.name, csr_r_data, x.rd);
    end
    @(posedge clk);
    #1;
    exec_en = 1'b0;
  endtask

  task automatic pulse_irq();
    intrpt_req = 1'b1;
    idle(1);
    intrpt_req = 1'b0;
    idle(4);
  endtask

  task automatic test_reset();
    intrpt_req = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (intrpt_taken !== 1'b0 || csr_r_data !== 32'h0 || mepc !== 32'h0 || mstatus_mie !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got taken=%b rd=%h mepc=%h mie=%b expected all 0",
               intrpt_taken, csr_r_data, mepc, mstatus_mie);
    end
    checks++;
    if (mtvec !== MTVEC_RST) begin
      errors++;
      $display("FAIL reset_mtvec: got %h expected %h", mtvec, MTVEC_RST);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, NOP, 32'h0, 32'h0, 0, 32'h0, "post_reset_no_trap");
    step(1, csrrw(12'h344), 32'h4, 32'h0, 0, 32'h800, "held_req_pending");
    intrpt_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    step(1, csrrw(12'h344), 32'h4, 32'h0, 0, 32'h0, "reset_clears_pend");
  endtask

  task automatic test_csrrw();
    step(1, csrrw(12'h305), 32'h10, 32'h0000_1003, 0, MTVEC_RST, "mtvec_write");
    checks++;
    if (mtvec !== 32'h0000_1000) begin
      errors++;
      $display("FAIL mtvec_value: got %h expected %h", mtvec, 32'h0000_1000);
    end
    step(1, csrrw(12'h305), 32'h14, 32'h0000_1000, 0, 32'h0000_1000, "mtvec_reread");
    step(0, csrrw(12'h305), 32'h18, 32'h0000_2000, 0, 32'h0, "no_exec_read");
    checks++;
    if (mtvec !== 32'h0000_1000) begin
      errors++;
      $display("FAIL no_exec_write: got %h expected %h", mtvec, 32'h0000_1000);
    end
    step(1, csrrw(12'h123), 32'h1c, 32'hFFFF_FFFF, 0, 32'h0, "unmapped_read");
    step(1, csrrw(12'h300), 32'h20, 32'hFFFF_FFFF, 0, 32'h0, "mstatus_write_all");
    step(1, csrrw(12'h300), 32'h24, 32'h0, 0, 32'h88, "mstatus_masked");
    step(1, csrrw(12'h341), 32'h28, 32'h0000_0207, 0, 32'h0, "mepc_write");
    step(1, csrrw(12'h341), 32'h2c, 32'h0, 0, 32'h0000_0204, "mepc_masked");
    step(1, csrrw(12'h344), 32'h30, 32'hFFFF_FFFF, 0, 32'h0, "mip_write");
    step(1, csrrw(12'h344), 32'h34, 32'h0, 0, 32'h0, "mip_readonly");
    step(1, NOP, 32'h38, 32'hFFFF_FFFF, 0, 32'h0, "nop_rdata_zero");
  endtask

  task automatic test_enable_trap();
    step(1, csrrw(12'h300), 32'h3c, 32'h8, 0, 32'h0, "enable_mie");
    step(1, csrrw(12'h304), 32'h40, 32'hFFFF_FFFF, 0, 32'h0, "enable_meie");
    step(1, csrrw(12'h304), 32'h44, 32'h800, 0, 32'h800, "meie_masked");
    checks++;
    if (mstatus_mie !== 1'b1) begin
      errors++;
      $display("FAIL mie_enabled: got %b expected 1", mstatus_mie);
    end
    pulse_irq();
    step(1, csrrw(12'h305), 32'h0000_0043, 32'h0000_DEAD, 1, 32'h0, "trap_collision");
    checks++;
    if (mepc !== 32'h40 || mtvec !== 32'h0000_1000 || mstatus_mie !== 1'b0) begin
      errors++;
      $display("FAIL trap_state: got mepc=%h mtvec=%h mie=%b expected 00000040 00001000 0",
               mepc, mtvec, mstatus_mie);
    end
    step(1, csrrw(12'h342), 32'h1000, 32'h0, 0, 32'h8000_000B, "mcause_ext");
    step(1, csrrw(12'h300), 32'h1004, 32'h80, 0, 32'h80, "mstatus_after_trap");
    step(1, csrrw(12'h344), 32'h1008, 32'h0, 0, 32'h0, "mip_cleared");
  endtask

  task automatic test_mret();
    step(1, MRET, 32'h100C, 32'h0, 0, 32'h0, "mret");
    checks++;
    if (mstatus_mie !== 1'b1 || mepc !== 32'h40) begin
      errors++;
      $display("FAIL mret_state: got mie=%b mepc=%h expected 1 00000040", mstatus_mie, mepc);
    end
    step(1, csrrw(12'h300), 32'h44, 32'h88, 0, 32'h88, "mstatus_after_mret");
  endtask

  task automatic test_masked();
    step(1, csrrw(12'h300), 32'h200, 32'h0, 0, 32'h88, "disable_mie");
    pulse_irq();
    step(1, NOP, 32'h204, 32'h0, 0, 32'h0, "masked_no_trap");
    step(1, csrrw(12'h344), 32'h208, 32'h0, 0, 32'h800, "masked_mip");
    step(1, csrrw(12'h300), 32'h20C, 32'h8, 0, 32'h0, "enable_no_same_cycle");
    step(1, NOP, 32'h212, 32'h0, 1, 32'h0, "trap_next_instr");
    checks++;
    if (mepc !== 32'h210) begin
      errors++;
      $display("FAIL masked_mepc: got %h expected %h", mepc, 32'h210);
    end
  endtask

  task automatic test_back_to_back();
    step(1, MRET, 32'h300, 32'h0, 0, 32'h0, "mret_reenable");
    pulse_irq();
    intrpt_req = 1'b1;
    idle(2);
    step(1, csrrw(12'h305), 32'h304, 32'h0000_5555, 1, 32'h0, "collision_taken");
    checks++;
    if (mtvec !== 32'h0000_1000) begin
      errors++;
      $display("FAIL collision_mtvec: got %h expected %h", mtvec, 32'h0000_1000);
    end
    step(1, csrrw(12'h344), 32'h308, 32'h0, 0, 32'h800, "collision_set_wins");
    intrpt_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csrrw();
    test_enable_trap();
    test_mret();
    test_masked();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
